// File: rtl/jt6295_cmd.sv
// jt6295_cmd: decodes the two-byte CPU command protocol, fetches the 6-byte
// phrase header from sample ROM and drives the serial engine's channel controls.
module jt6295_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen4,
  input  logic        zero,
  input  logic        wrn,
  input  logic [7:0]  din,
  input  logic [3:0]  busy,
  output logic        cmd_busy,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr,
  output logic [3:0]  att,
  output logic [3:0]  start,
  output logic [3:0]  stop
);

  typedef enum logic [2:0] {IDLE, PHRASE, FETCH, ARM, HOLD} state_t;

  state_t      state_q, state_d;
  logic        wrn_q;
  logic [6:0]  phrase_q, phrase_d;
  logic [3:0]  chMask_q, chMask_d;
  logic [3:0]  attLatch_q, attLatch_d;
  logic [2:0]  idx_q, idx_d;
  logic        addrNew_q, addrNew_d;
  logic        romCs_q, romCs_d;
  logic [17:0] romAddr_q, romAddr_d;
  logic [17:0] hdrStart_q, hdrStart_d;
  logic [17:0] hdrStop_q, hdrStop_d;
  logic [17:0] startAddr_q, startAddr_d;
  logic [17:0] stopAddr_q, stopAddr_d;
  logic [3:0]  att_q, att_d;
  logic [3:0]  start_q, start_d;
  logic [3:0]  stop_q, stop_d;
  logic        wrStb, sweep, stopWr;

  assign wrStb  = wrn_q & ~wrn;
  assign sweep  = zero & cen4;
  assign stopWr = wrStb & ~din[7] & (state_q != PHRASE);

  assign cmd_busy   = (state_q == FETCH) || (state_q == ARM) || (state_q == HOLD);
  assign rom_cs     = romCs_q;
  assign rom_addr   = romAddr_q;
  assign start_addr = startAddr_q;
  assign stop_addr  = stopAddr_q;
  assign att        = att_q;
  assign start      = start_q;
  assign stop       = stop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    phrase_d    = phrase_q;
    chMask_d    = chMask_q;
    attLatch_d  = attLatch_q;
    idx_d       = idx_q;
    addrNew_d   = addrNew_q;
    romCs_d     = romCs_q;
    romAddr_d   = romAddr_q;
    hdrStart_d  = hdrStart_q;
    hdrStop_d   = hdrStop_q;
    startAddr_d = startAddr_q;
    stopAddr_d  = stopAddr_q;
    att_d       = att_q;
    start_d     = start_q;
    stop_d      = stop_q;

    // A stop write coinciding with the sweep boundary survives the clear
    if (sweep)       stop_d = stopWr ? din[6:3] : 4'd0;
    else if (stopWr) stop_d = stop_q | din[6:3];

    case (state_q)
      IDLE: begin
        if (wrStb && din[7]) begin
          phrase_d = din[6:0];
          state_d  = PHRASE;
        end
      end
      PHRASE: begin
        if (wrStb) begin
          chMask_d   = din[7:4];
          attLatch_d = din[3:0];
          if (din[7:4] != 4'd0 && phrase_q != 7'd0) begin
            state_d   = FETCH;
            idx_d     = 3'd0;
            romCs_d   = 1'b1;
            romAddr_d = {8'd0, phrase_q, 3'd0};
            addrNew_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FETCH: begin
        // rom_ok is not trusted in the cycle the address changes
        if (idx_q == 3'd6) begin
          state_d     = ARM;
          startAddr_d = hdrStart_q;
          stopAddr_d  = hdrStop_q;
          att_d       = attLatch_q;
          start_d     = chMask_q & ~busy;
        end else if (addrNew_q) begin
          addrNew_d = 1'b0;
        end else if (rom_ok) begin
          case (idx_q)
            3'd0:    hdrStart_d[17:16] = rom_data[1:0];
            3'd1:    hdrStart_d[15:8]  = rom_data;
            3'd2:    hdrStart_d[7:0]   = rom_data;
            3'd3:    hdrStop_d[17:16]  = rom_data[1:0];
            3'd4:    hdrStop_d[15:8]   = rom_data;
            default: hdrStop_d[7:0]    = rom_data;
          endcase
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd5) begin
            romCs_d = 1'b0;
          end else begin
            romAddr_d = {8'd0, phrase_q, idx_q + 3'd1};
            addrNew_d = 1'b1;
          end
        end
      end
      ARM: begin
        if (start_q == 4'd0) begin
          state_d = IDLE;
        end else if (sweep) begin
          start_d = 4'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (sweep) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrn_q       <= 1'b1;
      phrase_q    <= 7'd0;
      chMask_q    <= 4'd0;
      attLatch_q  <= 4'd0;
      idx_q       <= 3'd0;
      addrNew_q   <= 1'b0;
      romCs_q     <= 1'b0;
      romAddr_q   <= 18'd0;
      hdrStart_q  <= 18'd0;
      hdrStop_q   <= 18'd0;
      startAddr_q <= 18'd0;
      stopAddr_q  <= 18'd0;
      att_q       <= 4'd0;
      start_q     <= 4'd0;
      stop_q      <= 4'd0;
    end else begin
      wrn_q       <= wrn;
      phrase_q    <= phrase_d;
      chMask_q    <= chMask_d;
      attLatch_q  <= attLatch_d;
      idx_q       <= idx_d;
      addrNew_q   <= addrNew_d;
      romCs_q     <= romCs_d;
      romAddr_q   <= romAddr_d;
      hdrStart_q  <= hdrStart_d;
      hdrStop_q   <= hdrStop_d;
      startAddr_q <= startAddr_d;
      stopAddr_q  <= stopAddr_d;
      att_q       <= att_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

endmodule
